fetch_stage: RTL

Instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline. Owns the PC, selects the next PC (sequential, branch, jump) and drives instruction memory through a req/ready handshake. Presents the fetched instruction to decode, holding it when the hazard-detection unit raises `stall` and replacing it with a bubble on a taken branch, a jump, or an imem miss. Also keeps saturating stall and flush counters for performance debug.

---
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the 5-stage MIPS pipeline.
// Owns the PC and picks the next PC: sequential, branch target or jump target.
// Drives instruction memory through a req/ready handshake.
// Presents the fetched instruction to decode. On a stall the IF/ID register holds.
// On a redirect or an imem miss the IF/ID register takes a bubble.
// Saturating stall and flush counters are kept for performance debug.
//
// Ports:
//   i_clk            rising-edge clock
//   i_reset          synchronous, active-high reset
//   i_stall          hold request from hazard detection
//   i_branch_taken   branch resolved taken in ID
//   i_branch_target  branch destination
//   i_jump           jump decoded in ID (wins over a branch)
//   i_jump_target    jump destination
//   o_imem_req       fetch request (combinational, !reset)
//   o_imem_addr      fetch address (combinational, current PC)
//   i_imem_rdata     instruction, valid when i_imem_ready
//   i_imem_ready     imem accepts the request and returns data this cycle
//   o_instr_id       IF/ID instruction
//   o_pc_plus4_id    IF/ID PC+4
//   o_valid_id       IF/ID holds a real instruction
//   o_stall_count    saturating count of honoured stall cycles
//   o_flush_count    saturating count of redirects taken
module fetch_stage #(
    parameter int unsigned         LEN_PC    = 32,
    parameter int unsigned         LEN_INSTR = 32,
    parameter logic [LEN_PC-1:0]   RESET_PC  = '0,
    parameter logic [LEN_INSTR-1:0] NOP_INSTR = '0,
    parameter int unsigned         LEN_CNT   = 16
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stall,
    input  logic                 i_branch_taken,
    input  logic [LEN_PC-1:0]    i_branch_target,
    input  logic                 i_jump,
    input  logic [LEN_PC-1:0]    i_jump_target,
    output logic                 o_imem_req,
    output logic [LEN_PC-1:0]    o_imem_addr,
    input  logic [LEN_INSTR-1:0] i_imem_rdata,
    input  logic                 i_imem_ready,
    output logic [LEN_INSTR-1:0] o_instr_id,
    output logic [LEN_PC-1:0]    o_pc_plus4_id,
    output logic                 o_valid_id,
    output logic [LEN_CNT-1:0]   o_stall_count,
    output logic [LEN_CNT-1:0]   o_flush_count
);

    typedef enum logic {
        S_FETCH = 1'b0,
        S_WAIT  = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [LEN_PC-1:0]    r_pc;
    logic [LEN_INSTR-1:0] r_instr_id;
    logic [LEN_PC-1:0]    r_pc_plus4_id;
    logic                 r_valid_id;
    logic [LEN_CNT-1:0]   r_stall_count;
    logic [LEN_CNT-1:0]   r_flush_count;

    logic [LEN_PC-1:0]    w_pc_next;
    logic [LEN_INSTR-1:0] w_instr_next;
    logic [LEN_PC-1:0]    w_pc_plus4_next;
    logic                 w_valid_next;
    logic [LEN_CNT-1:0]   w_stall_count_next;
    logic [LEN_CNT-1:0]   w_flush_count_next;

    logic [LEN_PC-1:0]    w_pc_plus4;
    logic                 w_redirect;
    logic [LEN_PC-1:0]    w_target;
    logic [LEN_PC-1:0]    w_target_aligned;

    // Sequential PC; wraps naturally modulo 2^LEN_PC
    assign w_pc_plus4 = r_pc + LEN_PC'(4);

    // Jump has priority over branch; targets are forced to word alignment
    assign w_redirect       = i_jump | i_branch_taken;
    assign w_target         = i_jump ? i_jump_target : i_branch_target;
    assign w_target_aligned = {w_target[LEN_PC-1:2], 2'b00};

    // Fetch request tracks reset only, so it stays up through stalls and misses
    assign o_imem_req  = ~i_reset;
    assign o_imem_addr = r_pc;

    // State register and IF/ID pipeline register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= S_FETCH;
            r_pc          <= RESET_PC;
            r_instr_id    <= NOP_INSTR;
            r_pc_plus4_id <= '0;
            r_valid_id    <= 1'b0;
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_pc          <= w_pc_next;
            r_instr_id    <= w_instr_next;
            r_pc_plus4_id <= w_pc_plus4_next;
            r_valid_id    <= w_valid_next;
            r_stall_count <= w_stall_count_next;
            r_flush_count <= w_flush_count_next;
        end
    end

    // Next state: stall > redirect > miss > advance
    always_comb begin
        w_state_next = r_state;
        if (i_stall) begin
            w_state_next = r_state;
        end else if (w_redirect) begin
            // Any outstanding request is abandoned; start fresh at the target
            w_state_next = S_FETCH;
        end else begin
            case (r_state)
                S_FETCH: w_state_next = i_imem_ready ? S_FETCH : S_WAIT;
                S_WAIT:  w_state_next = i_imem_ready ? S_FETCH : S_WAIT;
                default: w_state_next = S_FETCH;
            endcase
        end
    end

    // Next PC, IF/ID payload and counters
    always_comb begin
        w_pc_next          = r_pc;
        w_instr_next       = r_instr_id;
        w_pc_plus4_next    = r_pc_plus4_id;
        w_valid_next       = r_valid_id;
        w_stall_count_next = r_stall_count;
        w_flush_count_next = r_flush_count;

        if (i_stall) begin
            // Everything holds; a ready seen now is discarded and the branch re-evaluates later
            if (r_stall_count != {LEN_CNT{1'b1}}) begin
                w_stall_count_next = r_stall_count + LEN_CNT'(1);
            end
        end else if (w_redirect) begin
            w_pc_next       = w_target_aligned;
            w_instr_next    = NOP_INSTR;
            w_pc_plus4_next = '0;
            w_valid_next    = 1'b0;
            if (r_flush_count != {LEN_CNT{1'b1}}) begin
                w_flush_count_next = r_flush_count + LEN_CNT'(1);
            end
        end else if (!i_imem_ready) begin
            w_instr_next    = NOP_INSTR;
            w_pc_plus4_next = '0;
            w_valid_next    = 1'b0;
        end else begin
            w_pc_next       = w_pc_plus4;
            w_instr_next    = i_imem_rdata;
            w_pc_plus4_next = w_pc_plus4;
            w_valid_next    = 1'b1;
        end
    end

    assign o_instr_id    = r_instr_id;
    assign o_pc_plus4_id = r_pc_plus4_id;
    assign o_valid_id    = r_valid_id;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;

endmodule
